// File: rtl/fft_butterfly_unit.sv
// Pipelined radix-2 DIT butterfly for the in-place FFT core.
// Each valid sample pair x1, x2 with twiddle W produces (x1 + W*x2)/2 and
// (x1 - W*x2)/2. The pair's write-back addresses and a valid strobe are
// delivered with the results exactly mult_latency+1 cycles after i_valid.
module fft_butterfly_unit #(
  parameter int N             = 32,
  parameter int word_size     = 16,
  parameter int address_width = $clog2(N),
  parameter int mult_latency  = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_valid,
  input  logic [address_width-1:0]   address1,
  input  logic [address_width-1:0]   address2,
  input  logic [2*word_size-1:0]     twiddle,
  input  logic [2*word_size-1:0]     sample1,
  input  logic [2*word_size-1:0]     sample2,
  output logic [2*word_size-1:0]     comp1,
  output logic [2*word_size-1:0]     comp2,
  output logic [address_width-1:0]   wr_address1,
  output logic [address_width-1:0]   wr_address2,
  output logic                       d_valid
);

  localparam int WS   = word_size;
  localparam int PW   = word_size + 1;      // scaled product width
  localparam int FW   = 2 * word_size + 1;  // full-precision product width
  localparam int SW   = word_size + 2;      // add/sub width
  localparam int LAST = mult_latency - 1;

  // Sign-extend one component to full product precision.
  function automatic logic signed [FW-1:0] sext_full(input logic signed [WS-1:0] v);
    return {{(FW - WS){v[WS-1]}}, v};
  endfunction

  // p*q +/- r*t at full precision, floor-shifted back to Q1 and kept at word_size+1 bits.
  function automatic logic signed [PW-1:0] mac_scale(
    input logic signed [WS-1:0] p,
    input logic signed [WS-1:0] q,
    input logic signed [WS-1:0] r,
    input logic signed [WS-1:0] t,
    input logic                 subtract
  );
    logic signed [FW-1:0] pq;
    logic signed [FW-1:0] rt;
    logic signed [FW-1:0] acc;
    pq = sext_full(p) * sext_full(q);
    rt = sext_full(r) * sext_full(t);
    if (subtract) begin
      acc = pq - rt;
    end else begin
      acc = pq + rt;
    end
    acc = acc >>> (WS - 1);
    return acc[PW-1:0];
  endfunction

  // (x +/- p) floor-halved and truncated to word_size bits; wraps rather than saturates.
  function automatic logic [WS-1:0] half_step(
    input logic signed [WS-1:0] x,
    input logic signed [PW-1:0] p,
    input logic                 subtract
  );
    logic signed [SW-1:0] xe;
    logic signed [SW-1:0] pe;
    logic signed [SW-1:0] r;
    xe = {{2{x[WS-1]}}, x};
    pe = {p[PW-1], p};
    if (subtract) begin
      r = xe - pe;
    end else begin
      r = xe + pe;
    end
    return r[WS:1];
  endfunction

  logic signed [WS-1:0] x2_re_s, x2_im_s, w_re_s, w_im_s;
  logic signed [PW-1:0] p_re_s, p_im_s;

  logic [address_width-1:0] addr1_in_r, addr2_in_r;
  logic [mult_latency-1:0]  vld_pipe_r;
  logic signed [PW-1:0]     p_re_pipe_r [mult_latency];
  logic signed [PW-1:0]     p_im_pipe_r [mult_latency];
  logic [2*WS-1:0]          x1_pipe_r   [mult_latency];
  logic [address_width-1:0] a1_pipe_r   [mult_latency];
  logic [address_width-1:0] a2_pipe_r   [mult_latency];

  assign x2_re_s = sample2[2*WS-1:WS];
  assign x2_im_s = sample2[WS-1:0];
  assign w_re_s  = twiddle[2*WS-1:WS];
  assign w_im_s  = twiddle[WS-1:0];

  // P = W*x2: Pr = a*c - b*d, Pi = a*d + b*c.
  assign p_re_s = mac_scale(x2_re_s, w_re_s, x2_im_s, w_im_s, 1'b1);
  assign p_im_s = mac_scale(x2_re_s, w_im_s, x2_im_s, w_re_s, 1'b0);

  // Addresses lead the samples by one cycle; this register brings them into step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr1_in_r <= '0;
      addr2_in_r <= '0;
    end else begin
      addr1_in_r <= address1;
      addr2_in_r <= address2;
    end
  end

  // Multiply pipeline: product, x1, addresses and the slot valid bit advance together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe_r <= '0;
      for (int i = 0; i < mult_latency; i++) begin
        p_re_pipe_r[i] <= '0;
        p_im_pipe_r[i] <= '0;
        x1_pipe_r[i]   <= '0;
        a1_pipe_r[i]   <= '0;
        a2_pipe_r[i]   <= '0;
      end
    end else begin
      vld_pipe_r[0]  <= i_valid;
      p_re_pipe_r[0] <= p_re_s;
      p_im_pipe_r[0] <= p_im_s;
      x1_pipe_r[0]   <= sample1;
      a1_pipe_r[0]   <= addr1_in_r;
      a2_pipe_r[0]   <= addr2_in_r;
      for (int i = 1; i < mult_latency; i++) begin
        vld_pipe_r[i]  <= vld_pipe_r[i-1];
        p_re_pipe_r[i] <= p_re_pipe_r[i-1];
        p_im_pipe_r[i] <= p_im_pipe_r[i-1];
        x1_pipe_r[i]   <= x1_pipe_r[i-1];
        a1_pipe_r[i]   <= a1_pipe_r[i-1];
        a2_pipe_r[i]   <= a2_pipe_r[i-1];
      end
    end
  end

  // Add/sub output stage: loads only for a valid slot, otherwise holds results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_valid     <= 1'b0;
      comp1       <= '0;
      comp2       <= '0;
      wr_address1 <= '0;
      wr_address2 <= '0;
    end else begin
      d_valid <= vld_pipe_r[LAST];
      if (vld_pipe_r[LAST]) begin
        comp1 <= {half_step(x1_pipe_r[LAST][2*WS-1:WS], p_re_pipe_r[LAST], 1'b0),
                  half_step(x1_pipe_r[LAST][WS-1:0],    p_im_pipe_r[LAST], 1'b0)};
        comp2 <= {half_step(x1_pipe_r[LAST][2*WS-1:WS], p_re_pipe_r[LAST], 1'b1),
                  half_step(x1_pipe_r[LAST][WS-1:0],    p_im_pipe_r[LAST], 1'b1)};
        wr_address1 <= a1_pipe_r[LAST];
        wr_address2 <= a2_pipe_r[LAST];
      end else begin
        comp1       <= comp1;
        comp2       <= comp2;
        wr_address1 <= wr_address1;
        wr_address2 <= wr_address2;
      end
    end
  end

endmodule

// File: tb/tb_fft_butterfly_unit.sv
// Self-checking bench for fft_butterfly_unit (N=32, word_size=16, mult_latency=3).
module tb_fft_butterfly_unit;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid;
  logic [4:0]  address1, address2;
  logic [31:0] twiddle, sample1, sample2;
  logic [31:0] comp1, comp2;
  logic [4:0]  wr_address1, wr_address2;
  logic        d_valid;

  fft_butterfly_unit dut (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (i_valid),
    .address1    (address1),
    .address2    (address2),
    .twiddle     (twiddle),
    .sample1     (sample1),
    .sample2     (sample2),
    .comp1       (comp1),
    .comp2       (comp2),
    .wr_address1 (wr_address1),
    .wr_address2 (wr_address2),
    .d_valid     (d_valid)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] w;
  } stim_t;

  typedef struct {
    int          due;
    logic [31:0] c1;
    logic [31:0] c2;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fails  = 0;
  int    cyc      = 0;
  logic [31:0] hold_c1, hold_c2;
  logic [4:0]  hold_a1, hold_a2;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pk(int re, int im);
    return {re[15:0], im[15:0]};
  endfunction

  function automatic longint sx16(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Keep the low 'bits' bits of v as a signed number.
  function automatic longint wrap(longint v, int bits);
    longint t;
    t = v <<< (64 - bits);
    return t >>> (64 - bits);
  endfunction

  // Reference butterfly from the arithmetic rules, using wide integers.
  task automatic ref_pair(input logic [31:0] s1, s2, w, output logic [31:0] c1, c2);
    longint a, b, c, d, x1r, x1i, pr, pi;
    logic [15:0] c1r, c1i, c2r, c2i;
    a   = sx16(s2[31:16]);  b   = sx16(s2[15:0]);
    c   = sx16(w[31:16]);   d   = sx16(w[15:0]);
    x1r = sx16(s1[31:16]);  x1i = sx16(s1[15:0]);
    pr  = wrap((a * c - b * d) >>> 15, 17);
    pi  = wrap((a * d + b * c) >>> 15, 17);
    c1r = 16'((x1r + pr) >>> 1);
    c1i = 16'((x1i + pi) >>> 1);
    c2r = 16'((x1r - pr) >>> 1);
    c2i = 16'((x1i - pi) >>> 1);
    c1  = {c1r, c1i};
    c2  = {c2r, c2i};
  endtask

  task automatic add(bit v, logic [4:0] a1, logic [4:0] a2, logic [31:0] s1, logic [31:0] s2, logic [31:0] w);
    stim_t s;
    s.v = v; s.a1 = a1; s.a2 = a2; s.s1 = s1; s.s2 = s2; s.w = w;
    stim_q.push_back(s);
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Compare all outputs against the expectation for the current cycle.
  task automatic check_cycle();
    bit   expv;
    exp_t e;
    expv = (exp_q.size() > 0) && (exp_q[0].due == cyc);
    if (expv) begin
      e = exp_q.pop_front();
      hold_c1 = e.c1; hold_c2 = e.c2; hold_a1 = e.a1; hold_a2 = e.a2;
    end
    check_eq("d_valid",     64'(d_valid),     64'(expv));
    check_eq("comp1",       64'(comp1),       64'(hold_c1));
    check_eq("comp2",       64'(comp2),       64'(hold_c2));
    check_eq("wr_address1", 64'(wr_address1), 64'(hold_a1));
    check_eq("wr_address2", 64'(wr_address2), 64'(hold_a2));
  endtask

  // Play stim_q; addresses go out one cycle before their samples. Called just after a posedge.
  task automatic run_stream(int drain);
    exp_t e;
    for (int c = -1; c < stim_q.size() + drain; c++) begin
      if (c >= 0 && c < stim_q.size()) begin
        i_valid = stim_q[c].v;
        sample1 = stim_q[c].s1;
        sample2 = stim_q[c].s2;
        twiddle = stim_q[c].w;
        if (stim_q[c].v) begin
          e.due = cyc + LAT;
          e.a1  = stim_q[c].a1;
          e.a2  = stim_q[c].a2;
          ref_pair(stim_q[c].s1, stim_q[c].s2, stim_q[c].w, e.c1, e.c2);
          exp_q.push_back(e);
        end
      end else begin
        i_valid = 1'b0;
        sample1 = $urandom;
        sample2 = $urandom;
        twiddle = $urandom;
      end
      if (c + 1 < stim_q.size()) begin
        address1 = stim_q[c+1].a1;
        address2 = stim_q[c+1].a2;
      end else begin
        address1 = 5'($urandom);
        address2 = 5'($urandom);
      end
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      cyc++;
      #1;
    end
    stim_q.delete();
  endtask

  // Asynchronous reset pulse taken mid-cycle; in-flight pairs are discarded.
  task automatic do_reset();
    i_valid = 1'b0;
    reset   = 1'b0;
    #2;
    check_eq("rst_d_valid", 64'(d_valid),     64'd0);
    check_eq("rst_comp1",   64'(comp1),       64'd0);
    check_eq("rst_comp2",   64'(comp2),       64'd0);
    check_eq("rst_wr_addr1",64'(wr_address1), 64'd0);
    check_eq("rst_wr_addr2",64'(wr_address2), 64'd0);
    exp_q.delete();
    hold_c1 = '0; hold_c2 = '0; hold_a1 = '0; hold_a2 = '0;
    @(posedge clk);
    cyc++;
    @(posedge clk);
    cyc++;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; i_valid = 1'b0;
    address1 = '0; address2 = '0; twiddle = '0; sample1 = '0; sample2 = '0;
    hold_c1 = '0; hold_c2 = '0; hold_a1 = '0; hold_a2 = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_reset();

    // Directed arithmetic cases.
    add(1'b1, 5'd3, 5'd19, pk(1000, 0), pk(200, 0), pk(32767, 0));
    add(1'b1, 5'd4, 5'd20, pk(0, 0), pk(200, 100), pk(0, -32768));
    add(1'b1, 5'd5, 5'd21, pk(-32768, -32768), pk(-32768, -32768), pk(32767, 0));
    run_stream(6);
    check_eq("drain_directed", 64'(exp_q.size()), 64'd0);

    // Streaming: 8 back-to-back pairs.
    for (int i = 0; i < 8; i++) begin
      add(1'b1, 5'(i), 5'(16 + i), $urandom, $urandom, $urandom);
    end
    run_stream(6);
    check_eq("drain_stream", 64'(exp_q.size()), 64'd0);

    // Bubbles: 1,0,1,1,0,1.
    add(1'b1, 5'd1, 5'd17, pk(100, -7), pk(300, 40), pk(23170, -23170));
    add(1'b0, 5'd2, 5'd18, $urandom, $urandom, $urandom);
    add(1'b1, 5'd3, 5'd19, pk(-5, 9), pk(1234, -4321), pk(0, 32767));
    add(1'b1, 5'd4, 5'd20, pk(777, 888), pk(-999, 111), pk(-32768, 0));
    add(1'b0, 5'd5, 5'd21, $urandom, $urandom, $urandom);
    add(1'b1, 5'd6, 5'd22, pk(32767, 32767), pk(32767, 32767), pk(32767, 32767));
    run_stream(6);
    check_eq("drain_bubbles", 64'(exp_q.size()), 64'd0);

    // Reset with the pipeline full: nothing in flight may emerge afterwards.
    for (int i = 0; i < 6; i++) begin
      add(1'b1, 5'(i + 8), 5'(i + 24), $urandom, $urandom, $urandom);
    end
    run_stream(0);
    do_reset();
    for (int i = 0; i < 8; i++) begin
      add(1'b0, 5'(i), 5'(i), $urandom, $urandom, $urandom);
    end
    run_stream(0);
    check_eq("post_reset_idle", 64'(exp_q.size()), 64'd0);

    // Randomized traffic with boundary-heavy operands.
    for (int i = 0; i < 300; i++) begin
      add($urandom_range(0, 3) != 0, 5'($urandom), 5'($urandom),
          {rnd16(), rnd16()}, {rnd16(), rnd16()}, {rnd16(), rnd16()});
    end
    run_stream(6);
    check_eq("drain_random", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
